// File: rtl/execute_pkg.sv
// Shared opcode, state and lane-vector types for the execute dispatcher.
package execute_pkg;

  localparam int EXEC_N       = 32;
  localparam int EXEC_ALU_NUM = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_CMP = 3'd7
  } exec_instr_t;

  typedef logic [1:0] disp_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef logic signed [EXEC_ALU_NUM-1:0][EXEC_N-1:0] lane_vec_t;

endpackage

// File: rtl/exec_watchdog.sv
// Operation watchdog: down-counter loaded when an op is issued, expires on the
// TMO_CYC-th cycle spent in ISSUE/WAIT. Only used with EXEC_DISPATCH_TIMEOUT_EN.
module exec_watchdog #(
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  logic [CW-1:0] cnt_d, cnt_q;

  // Count holds the number of in-flight cycles still remaining after this one.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(TMO_CYC - 1);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/execute_dispatch.sv
// Issue-side master for the lane-parallel ALU execute array, one op in flight.
// Optional watchdog abort enabled by defining EXEC_DISPATCH_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_ISSUE | first cycle with ex_* driven; ex_valid ignored (may be stale)
// ST_WAIT  | ex_* held until ex_valid (or watchdog expiry)
// ST_RESP  | res_* presented until res_ready
module execute_dispatch
  import execute_pkg::*;
#(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int ALU_NUM = 8,
  parameter int TMO_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_instr,
  input  logic [ALU_NUM-1:0]     req_mask,
  input  logic [ALU_NUM*N-1:0]   req_dataA,
  input  logic [ALU_NUM*N-1:0]   req_dataB,
  output logic [ALU_NUM-1:0]     ex_enable_alu,
  output logic [2:0]             ex_instr,
  output logic [ALU_NUM*N-1:0]   ex_dataA,
  output logic [ALU_NUM*N-1:0]   ex_dataB,
  input  logic                   ex_valid,
  input  logic                   ex_zero,
  input  logic [ALU_NUM*N-1:0]   ex_data_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ALU_NUM*N-1:0]   res_data,
  output logic                   res_zero,
  output logic                   res_err
);

  // Q is the fixed-point format of the lanes; data only passes through here.
  if ((Q < 0) || (Q >= N)) begin : g_bad_q
    $error("execute_dispatch: Q must lie in [0, N)");
  end
  if (TMO_CYC < 2) begin : g_bad_tmo
    $error("execute_dispatch: TMO_CYC must be at least 2");
  end

  disp_state_t             state_d, state_q;
  logic [ALU_NUM-1:0]      en_d, en_q;
  exec_instr_t             instr_d, instr_q;
  logic [ALU_NUM*N-1:0]    a_d, a_q;
  logic [ALU_NUM*N-1:0]    b_d, b_q;
  logic [ALU_NUM*N-1:0]    res_data_d, res_data_q;
  logic                    res_zero_d, res_zero_q;
  logic                    accept;

  assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef EXEC_DISPATCH_TIMEOUT_EN
  logic res_err_d, res_err_q;
  logic wdg_expired;
  logic in_flight;

  assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  exec_watchdog #(.TMO_CYC(TMO_CYC)) u_wdg (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (req_mask != '0)),
    .run     (in_flight),
    .expired (wdg_expired)
  );

  // Error is set only by a timeout; a real capture on the same cycle wins.
  always_comb begin
    res_err_d = res_err_q;
    if (accept) begin
      res_err_d = 1'b0;
    end else if ((state_q == ST_WAIT) && !ex_valid && wdg_expired) begin
      res_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_q <= 1'b0;
    end else begin
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    instr_d    = instr_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          instr_d = exec_instr_t'(req_instr);
          a_d     = req_dataA;
          b_d     = req_dataB;
          en_d    = req_mask;
          if (req_mask != '0) begin
            state_d = ST_ISSUE;
          end else begin
            res_data_d = '0;
            res_zero_d = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ex_valid) begin
          res_data_d = ex_data_out;
          res_zero_d = ex_zero;
          en_d       = '0;
          state_d    = ST_RESP;
        end
`ifdef EXEC_DISPATCH_TIMEOUT_EN
        else if (wdg_expired) begin
          res_data_d = '0;
          res_zero_d = 1'b0;
          en_d       = '0;
          state_d    = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      en_q       <= '0;
      instr_q    <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      instr_q    <= instr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign res_valid     = (state_q == ST_RESP);
  assign ex_enable_alu = en_q;
  assign ex_instr      = instr_q;
  assign ex_dataA      = a_q;
  assign ex_dataB      = b_q;
  assign res_data      = res_data_q;
  assign res_zero      = res_zero_q;

endmodule

// File: tb/tb_execute_dispatch.sv
// Self-checking bench for execute_dispatch; the bench plays the execute array
// and judges timing/results against a cycle-count model of the dispatcher.
module tb_execute_dispatch;

  localparam int NB  = 32;
  localparam int AN  = 8;
  localparam int DW  = NB * AN;
  localparam int TMO = 64;
  localparam int BUDGET = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_instr;
  logic [AN-1:0] req_mask;
  logic [DW-1:0] req_dataA, req_dataB;
  logic [AN-1:0] ex_enable_alu;
  logic [2:0]    ex_instr;
  logic [DW-1:0] ex_dataA, ex_dataB;
  logic          ex_valid, ex_zero;
  logic [DW-1:0] ex_data_out;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic          res_zero, res_err;

  int checks = 0;
  int errors = 0;

  execute_dispatch #(.N(NB), .Q(16), .ALU_NUM(AN), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_mask(req_mask), .req_dataA(req_dataA), .req_dataB(req_dataB),
    .ex_enable_alu(ex_enable_alu), .ex_instr(ex_instr),
    .ex_dataA(ex_dataA), .ex_dataB(ex_dataB),
    .ex_valid(ex_valid), .ex_zero(ex_zero), .ex_data_out(ex_data_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_err(res_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < AN; i++) v[i*NB +: NB] = $urandom;
    return v;
  endfunction

  // Model: cycle 0 = accept cycle, ISSUE = cycle 1, ex_valid from cycle 1+d.
  // Capture needs a WAIT cycle (>= 2); result shows the cycle after capture.
  function automatic int exp_lat(input logic [AN-1:0] mask, input int d);
    int cap;
    if (mask == '0) return 1;
    cap = (d < 0) ? 1_000_000 : ((1 + d < 2) ? 2 : 1 + d);
`ifdef EXEC_DISPATCH_TIMEOUT_EN
    if (cap > TMO) return TMO + 1;
`endif
    return cap + 1;
  endfunction

  function automatic logic exp_err(input logic [AN-1:0] mask, input int d);
`ifdef EXEC_DISPATCH_TIMEOUT_EN
    if (mask != '0 && (d < 0 || 1 + d > TMO)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Runs one operation acting as the array; returns observations only.
  task automatic do_op(
    input  logic [2:0]    instr,
    input  logic [AN-1:0] mask,
    input  logic [DW-1:0] a, b, r,
    input  logic          z,
    input  int            d,
    input  logic          pre_valid,
    input  int            rdy_dly,
    input  logic          press,
    output int            lat,
    output logic [AN-1:0] en_at1,
    output logic [2:0]    instr_at1,
    output logic [DW-1:0] a_at1, b_at1,
    output int            n_changed,
    output logic [AN-1:0] en_or,
    output logic [AN-1:0] en_at_resp,
    output logic [DW-1:0] rdata,
    output logic          rzero, rerr,
    output int            n_hold_bad,
    output logic          rdy_after
  );
    lat = -1; en_at1 = '0; instr_at1 = '0; a_at1 = '0; b_at1 = '0;
    n_changed = 0; en_or = '0; en_at_resp = '0; rdata = '0;
    rzero = 1'b0; rerr = 1'b0; n_hold_bad = 0; rdy_after = 1'b0;
    req_valid = 1'b1; req_instr = instr; req_mask = mask;
    req_dataA = a; req_dataB = b;
    ex_valid = pre_valid; ex_data_out = ~r; ex_zero = ~z;
    tick();
    req_valid = 1'b0; req_mask = '1; req_dataA = rand_vec(); req_dataB = rand_vec();
    for (int k = 1; k <= BUDGET; k++) begin
      en_or |= ex_enable_alu;
      if (k == 1) begin
        en_at1 = ex_enable_alu; instr_at1 = ex_instr;
        a_at1 = ex_dataA; b_at1 = ex_dataB;
      end else if (ex_enable_alu != '0 &&
                   (ex_enable_alu != en_at1 || ex_instr != instr_at1 ||
                    ex_dataA != a_at1 || ex_dataB != b_at1)) begin
        n_changed++;
      end
      if (res_valid) begin
        lat = k;
        break;
      end
      ex_valid    = (d >= 0) && (k >= 1 + d);
      ex_data_out = (k >= 2) ? r : ~r;
      ex_zero     = (k >= 2) ? z : ~z;
      tick();
    end
    ex_valid = 1'b0;
    if (lat < 0) return;
    en_at_resp = ex_enable_alu; rdata = res_data; rzero = res_zero; rerr = res_err;
    for (int h = 0; h < rdy_dly; h++) begin
      res_ready = 1'b0; req_valid = press;
      tick();
      if (!res_valid || res_data != rdata || res_zero != rzero || res_err != rerr ||
          req_ready || ex_enable_alu != '0) n_hold_bad++;
    end
    req_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    rdy_after = req_ready && !res_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (ex_enable_alu !== '0) begin errors++; $display("FAIL reset_enable: got %h expected 0", ex_enable_alu); end
    checks++; if ({ex_instr, ex_dataA, ex_dataB} !== '0) begin errors++; $display("FAIL reset_ex_bus: got %h expected 0", {ex_instr, ex_dataA, ex_dataB}); end
    checks++; if ({res_data, res_zero, res_err} !== '0) begin errors++; $display("FAIL reset_res: got %h expected 0", {res_data, res_zero, res_err}); end
    rst = 1'b0;
  endtask

  task automatic test_add_full();
    logic [DW-1:0] a, b, r, rd, aa, bb;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra;
    int lat, nc, nh;
    for (int i = 0; i < AN; i++) begin
      a[i*NB +: NB] = NB'(i); b[i*NB +: NB] = NB'(1); r[i*NB +: NB] = NB'(i + 1);
    end
    do_op(3'd0, 8'hFF, a, b, r, 1'b0, 2, 1'b0, 0, 1'b0,
          lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    checks++; if (rd !== r) begin errors++; $display("FAIL add_data: got %h expected %h", rd, r); end
    checks++; if (e1 !== 8'hFF) begin errors++; $display("FAIL add_enable: got %h expected ff", e1); end
    checks++; if ({i1, aa, bb} !== {3'd0, a, b}) begin errors++; $display("FAIL add_ex_bus: got %h expected %h", {i1, aa, bb}, {3'd0, a, b}); end
    checks++; if (er !== '0) begin errors++; $display("FAIL add_enable_cleared: got %h expected 0", er); end
    checks++; if (nc !== 0) begin errors++; $display("FAIL add_ex_stable: got %0d changes expected 0", nc); end
    checks++; if (ex_dataA !== a) begin errors++; $display("FAIL add_dataA_kept: got %h expected %h", ex_dataA, a); end
  endtask

  task automatic test_mask_zero();
    logic [DW-1:0] a, b, rd, aa, bb;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra;
    int lat, nc, nh;
    a = rand_vec(); b = rand_vec();
    do_op(3'd5, '0, a, b, rand_vec(), 1'b0, 0, 1'b1, 1, 1'b0,
          lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    checks++; if (eo !== '0) begin errors++; $display("FAIL zero_no_enable: got %h expected 0", eo); end
    checks++; if ({rd, rz, re} !== {{DW{1'b0}}, 1'b1, 1'b0}) begin errors++; $display("FAIL zero_result: got %h/%b/%b expected 0/1/0", rd, rz, re); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL zero_back_idle: got %b expected 1", ra); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, r, rd, aa, bb;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra;
    int lat, nc, nh;
    a = rand_vec(); b = rand_vec(); r = rand_vec();
    do_op(3'd1, 8'h3C, a, b, r, 1'b1, 1, 1'b0, 10, 1'b1,
          lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", lat); end
    checks++; if (nh !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad hold cycles expected 0", nh); end
    checks++; if ({rd, rz} !== {r, 1'b1}) begin errors++; $display("FAIL bp_result: got %h/%b expected %h/1", rd, rz, r); end
    checks++; if (ex_dataA !== a) begin errors++; $display("FAIL bp_second_not_taken: got %h expected %h", ex_dataA, a); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", ra); end
  endtask

  task automatic test_stale_valid();
    logic [DW-1:0] r, rd, aa, bb;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra;
    int lat, nc, nh;
    r = rand_vec();
    do_op(3'd2, 8'h81, rand_vec(), rand_vec(), r, 1'b0, 0, 1'b1, 0, 1'b0,
          lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL stale_latency: got %0d expected 3", lat); end
    checks++; if ({rd, rz} !== {r, 1'b0}) begin errors++; $display("FAIL stale_data: got %h/%b expected %h/0", rd, rz, r); end
  endtask

  task automatic test_rst_mid();
    logic [DW-1:0] a, r, rd, aa, bb;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra;
    int lat, nc, nh;
    req_valid = 1'b1; req_mask = 8'hF0; req_instr = 3'd3;
    req_dataA = rand_vec(); req_dataB = rand_vec(); ex_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({req_ready, res_valid, ex_enable_alu} !== {1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL rst_mid_state: got rdy=%b rv=%b en=%h expected 1/0/00", req_ready, res_valid, ex_enable_alu); end
    a = rand_vec(); r = rand_vec();
    do_op(3'd0, 8'h0F, a, rand_vec(), r, 1'b1, 3, 1'b0, 0, 1'b0,
          lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rst_mid_next_latency: got %0d expected 5", lat); end
    checks++; if ({rd, rz, e1} !== {r, 1'b1, 8'h0F}) begin errors++; $display("FAIL rst_mid_next_result: got %h/%b/%h expected %h/1/0f", rd, rz, e1, r); end
  endtask

  task automatic test_long_wait();
    logic [DW-1:0] r, rd, aa, bb, xd;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra, xe;
    int lat, nc, nh;
    r = rand_vec();
    do_op(3'd4, 8'hAA, rand_vec(), rand_vec(), r, 1'b1, 150, 1'b0, 0, 1'b0,
          lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
    xe = exp_err(8'hAA, 150);
    xd = xe ? '0 : r;
    checks++; if (lat !== exp_lat(8'hAA, 150)) begin errors++; $display("FAIL long_latency: got %0d expected %0d", lat, exp_lat(8'hAA, 150)); end
    checks++; if ({rd, rz, re} !== {xd, !xe, xe}) begin errors++; $display("FAIL long_result: got %h/%b/%b expected %h/%b/%b", rd, rz, re, xd, !xe, xe); end
  endtask

`ifdef EXEC_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int ds[3] = '{63, 64, -1};
    logic [DW-1:0] r, rd, aa, bb, xd;
    logic [AN-1:0] e1, eo, er;
    logic [2:0] i1;
    logic rz, re, ra, xe;
    int lat, nc, nh;
    foreach (ds[j]) begin
      r = rand_vec();
      do_op(3'd0, 8'hFF, rand_vec(), rand_vec(), r, 1'b1, ds[j], 1'b0, 0, 1'b0,
            lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
      xe = exp_err(8'hFF, ds[j]);
      xd = xe ? '0 : r;
      checks++; if (lat !== exp_lat(8'hFF, ds[j])) begin errors++; $display("FAIL tmo_latency d=%0d: got %0d expected %0d", ds[j], lat, exp_lat(8'hFF, ds[j])); end
      checks++; if ({rd, rz, re, er} !== {xd, !xe, xe, 8'h00}) begin errors++; $display("FAIL tmo_result d=%0d: got %h/%b/%b/%h expected %h/%b/%b/00", ds[j], rd, rz, re, er, xd, !xe, xe); end
    end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] a, b, r, rd, aa, bb, xd;
    logic [AN-1:0] mask, e1, eo, er;
    logic [2:0] instr, i1;
    logic z, rz, re, ra;
    int d, lat, nc, nh;
    for (int it = 0; it < 24; it++) begin
      mask  = ($urandom_range(0, 3) == 0) ? '0 : AN'($urandom);
      instr = 3'($urandom);
      a = rand_vec(); b = rand_vec(); r = rand_vec();
      for (int i = 0; i < AN; i++) if (!mask[i]) r[i*NB +: NB] = '0;
      z = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 5);
      do_op(instr, mask, a, b, r, z, d, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            lat, e1, i1, aa, bb, nc, eo, er, rd, rz, re, nh, ra);
      xd = (mask == '0) ? '0 : r;
      checks++; if (lat !== exp_lat(mask, d)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, lat, exp_lat(mask, d)); end
      checks++; if ({rd, rz, re} !== {xd, (mask == '0) ? 1'b1 : z, 1'b0}) begin errors++; $display("FAIL rnd%0d_result: got %h/%b/%b", it, rd, rz, re); end
      checks++; if ({eo, er} !== {mask, 8'h00}) begin errors++; $display("FAIL rnd%0d_enables: got %h/%h expected %h/00", it, eo, er, mask); end
      checks++; if ({i1, aa, bb} !== {instr, a, b}) begin errors++; $display("FAIL rnd%0d_ex_bus: got %h expected %h", it, {i1, aa, bb}, {instr, a, b}); end
      checks++; if ({nc, nh} !== {32'd0, 32'd0}) begin errors++; $display("FAIL rnd%0d_stability: got %0d/%0d expected 0/0", it, nc, nh); end
      checks++; if (ra !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_after: got %b expected 1", it, ra); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_instr = '0; req_mask = '0;
    req_dataA = '0; req_dataB = '0; ex_valid = 1'b0; ex_zero = 1'b0;
    ex_data_out = '0; res_ready = 1'b0;
    test_reset();
    test_add_full();
    test_mask_zero();
    test_backpressure();
    test_stale_valid();
    test_rst_mid();
    test_long_wait();
`ifdef EXEC_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
